// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU share arbiter: ALU opcodes, flag bit positions and arbiter states.
// Optional feature macro used by this slice: ALU_ARB_STATS_EN (per-requester grant counters).
package alu_pkg;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      AND = 2'b10,
      OR  = 2'b11
   } alu_op_t;

   // Bit positions inside the 4-bit {N,Z,C,V} flag vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesting units (master) and the ALU share arbiter (slave).
interface alu_share_arbiter_if #(
   parameter int WIDTH = 64,
   parameter int NREQ  = 2
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ*2-1:0]     req_op;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [WIDTH-1:0]      rsp_result;
   logic [3:0]            rsp_flags;
   logic                  busy;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_flags, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_flags, busy
   );
endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Shared ALU: ADD/SUB/AND/OR on WIDTH-bit operands with {N,Z,C,V} flags; SUB is A + ~B + 1.
module Alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  alu_op_t          ALUControl,
   output logic [WIDTH-1:0] ALUResult,
   output logic [3:0]       ALUFlags
);

   logic             sub;
   logic             arith;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;

   // C is the raw adder carry-out, so for SUB it reads as "no borrow"
   always_comb begin
      sub       = (ALUControl == SUB);
      arith     = (ALUControl == ADD) || (ALUControl == SUB);
      b_eff     = sub ? ~SrcB : SrcB;
      sum       = {1'b0, SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
      ALUResult = '0;
      ALUFlags  = '0;
      case (ALUControl)
         ADD, SUB: ALUResult = sum[WIDTH-1:0];
         AND:      ALUResult = SrcA & SrcB;
         OR:       ALUResult = SrcA | SrcB;
         default:  ALUResult = '0;
      endcase
      ALUFlags[FLAG_N] = ALUResult[WIDTH-1];
      ALUFlags[FLAG_Z] = (ALUResult == '0);
      if (arith) begin
         ALUFlags[FLAG_C] = sum[WIDTH];
         ALUFlags[FLAG_V] = (SrcA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
   end

endmodule

// File: rtl/alu_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr wins, one-hot plus index.
module rr_picker
   import alu_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int PTRW = 1
) (
   input  logic [NREQ-1:0] req_valid,
   input  logic [PTRW-1:0] rr_ptr,
   output logic [NREQ-1:0] grant,
   output logic [PTRW-1:0] grant_idx
);

   logic found;
   int   idx;

   // Walk the requesters starting at the pointer, wrapping around, and keep the first hit
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int off = 0; off < NREQ; off++) begin
         idx = (int'(rr_ptr) + off) % NREQ;
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = PTRW'(idx);
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one Alu between NREQ requesters with round-robin grant and registered operands/results.
// Define ALU_ARB_STATS_EN to add the stat_grants port with saturating per-requester grant counters.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int NREQ  = 2
) (
   input  logic               clk,
   input  logic               reset,
   alu_share_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [NREQ*32-1:0] stat_grants
`endif
);

   localparam int PTRW = (NREQ > 2) ? 2 : 1;

   arb_state_t       state, next_state;
   logic [PTRW-1:0]  rr_ptr;
   logic [PTRW-1:0]  owner;
   logic [PTRW-1:0]  win_idx;
   logic [NREQ-1:0]  win_grant;
   logic [WIDTH-1:0] op_a, op_b;
   alu_op_t          op_code;
   logic [WIDTH-1:0] alu_result;
   logic [3:0]       alu_flags;
   logic [WIDTH-1:0] result_q;
   logic [3:0]       flags_q;
   logic [NREQ-1:0]  req_ready_c;
   logic [NREQ-1:0]  rsp_valid_c;
   logic             accept;
   logic             rsp_done;

   rr_picker #(.NREQ(NREQ), .PTRW(PTRW)) u_picker (
      .req_valid (bus.req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (win_grant),
      .grant_idx (win_idx)
   );

   Alu #(.WIDTH(WIDTH)) u_alu (
      .SrcA       (op_a),
      .SrcB       (op_b),
      .ALUControl (op_code),
      .ALUResult  (alu_result),
      .ALUFlags   (alu_flags)
   );

   // Next state and handshake strobes; only the owner's rsp_ready bit can close a response
   always_comb begin
      next_state  = state;
      req_ready_c = '0;
      rsp_valid_c = '0;
      accept      = 1'b0;
      rsp_done    = 1'b0;
      case (state)
         IDLE: begin
            if (|bus.req_valid) begin
               accept      = 1'b1;
               req_ready_c = win_grant;
               next_state  = EXEC;
            end
         end
         EXEC: next_state = RESP;
         RESP: begin
            rsp_valid_c[owner] = 1'b1;
            if (bus.rsp_ready[owner]) begin
               rsp_done   = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Pointer only advances on response completion, so an aborted op leaves fairness untouched
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         op_a     <= '0;
         op_b     <= '0;
         op_code  <= ADD;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            owner   <= win_idx;
            op_a    <= bus.req_a[win_idx*WIDTH +: WIDTH];
            op_b    <= bus.req_b[win_idx*WIDTH +: WIDTH];
            op_code <= alu_op_t'(bus.req_op[win_idx*2 +: 2]);
         end
         if (state == EXEC) begin
            result_q <= alu_result;
            flags_q  <= alu_flags;
         end
         if (rsp_done) begin
            rr_ptr <= (owner == PTRW'(NREQ - 1)) ? '0 : owner + PTRW'(1);
         end
      end
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.rsp_valid  = rsp_valid_c;
   assign bus.rsp_result = result_q;
   assign bus.rsp_flags  = flags_q;
   assign bus.busy       = (state != IDLE);

`ifdef ALU_ARB_STATS_EN
   logic [31:0] grant_cnt [NREQ];

   // Counters stick at all-ones rather than wrapping
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREQ; i++) begin
            grant_cnt[i] <= '0;
         end
      end else if (accept && (grant_cnt[win_idx] != 32'hFFFF_FFFF)) begin
         grant_cnt[win_idx] <= grant_cnt[win_idx] + 32'd1;
      end
   end

   always_comb begin
      stat_grants = '0;
      for (int i = 0; i < NREQ; i++) begin
         stat_grants[i*32 +: 32] = grant_cnt[i];
      end
   end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (2 requesters, 64-bit); stats checks need ALU_ARB_STATS_EN.
module tb_alu_share_arbiter;
   import alu_pkg::*;

   logic clk;
   logic reset;
   int   testCount;
   int   failCount;

   alu_share_arbiter_if #(.WIDTH(64), .NREQ(2)) bus ();

`ifdef ALU_ARB_STATS_EN
   logic [63:0] stat_grants;
`endif

   alu_share_arbiter #(.WIDTH(64), .NREQ(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef ALU_ARB_STATS_EN
      ,
      .stat_grants (stat_grants)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int idx, input logic v, input alu_op_t op,
                                input logic [63:0] a, input logic [63:0] b);
      bus.req_valid[idx]       = v;
      bus.req_op[idx*2 +: 2]   = op;
      bus.req_a[idx*64 +: 64]  = a;
      bus.req_b[idx*64 +: 64]  = b;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

`ifdef ALU_ARB_STATS_EN
   task automatic runTxn(input int idx);
      applyStimulus(idx, 1'b1, ADD, 64'd1, 64'd2);
      cycle();
      applyStimulus(idx, 1'b0, ADD, 64'd0, 64'd0);
      cycle();
      cycle();
   endtask
`endif

   initial begin
      testCount     = 0;
      failCount     = 0;
      reset         = 1'b1;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_op    = '0;
      bus.rsp_ready = '0;
      cycle();
      cycle();
      reset = 1'b0;
      #1;
      checkOutput("rst_busy", 64'(bus.busy), 64'd0);
      checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd0);
      checkOutput("rst_result", bus.rsp_result, 64'd0);
      checkOutput("rst_flags", 64'(bus.rsp_flags), 64'd0);

      // Test 1: req0 ADD 105+215
      bus.rsp_ready = 2'b11;
      applyStimulus(0, 1'b1, ADD, 64'd105, 64'd215);
      checkOutput("t1_req_ready", 64'(bus.req_ready), 64'b01);
      checkOutput("t1_idle_busy", 64'(bus.busy), 64'd0);
      cycle();
      applyStimulus(0, 1'b0, ADD, 64'd0, 64'd0);
      checkOutput("t1_exec_ready", 64'(bus.req_ready), 64'b00);
      checkOutput("t1_exec_rsp_valid", 64'(bus.rsp_valid), 64'b00);
      checkOutput("t1_exec_busy", 64'(bus.busy), 64'd1);
      cycle();
      checkOutput("t1_rsp_valid", 64'(bus.rsp_valid), 64'b01);
      checkOutput("t1_result", bus.rsp_result, 64'd320);
      checkOutput("t1_flags", 64'(bus.rsp_flags), 64'b0000);
      cycle();
      checkOutput("t1_done_busy", 64'(bus.busy), 64'd0);
      checkOutput("t1_done_rsp_valid", 64'(bus.rsp_valid), 64'b00);

      // Test 2: req1 SUB 105-105, pointer now favours req1
      applyStimulus(1, 1'b1, SUB, 64'd105, 64'd105);
      checkOutput("t2_req_ready", 64'(bus.req_ready), 64'b10);
      cycle();
      applyStimulus(1, 1'b0, ADD, 64'd0, 64'd0);
      cycle();
      checkOutput("t2_rsp_valid", 64'(bus.rsp_valid), 64'b10);
      checkOutput("t2_result", bus.rsp_result, 64'd0);
      checkOutput("t2_flags", 64'(bus.rsp_flags), 64'b0110);
      cycle();

      // Test 3: from reset, both valid; req0 AND first then req1 OR
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      applyStimulus(0, 1'b1, AND, 64'd105, 64'd215);
      applyStimulus(1, 1'b1, OR, 64'd105, 64'd215);
      checkOutput("t3_first_ready", 64'(bus.req_ready), 64'b01);
      cycle();
      applyStimulus(0, 1'b0, ADD, 64'd0, 64'd0);
      checkOutput("t3_exec_ready", 64'(bus.req_ready), 64'b00);
      cycle();
      checkOutput("t3_and_rsp_valid", 64'(bus.rsp_valid), 64'b01);
      checkOutput("t3_and_result", bus.rsp_result, 64'd65);
      checkOutput("t3_and_flags", 64'(bus.rsp_flags), 64'b0000);
      checkOutput("t3_resp_ready", 64'(bus.req_ready), 64'b00);
      cycle();
      checkOutput("t3_second_ready", 64'(bus.req_ready), 64'b10);
      checkOutput("t3_second_busy", 64'(bus.busy), 64'd0);
      cycle();
      applyStimulus(1, 1'b0, ADD, 64'd0, 64'd0);
      cycle();
      checkOutput("t3_or_rsp_valid", 64'(bus.rsp_valid), 64'b10);
      checkOutput("t3_or_result", bus.rsp_result, 64'd255);
      cycle();

      // Test 4: backpressure on req0 SUB 5-7; non-owner rsp_ready bit must be ignored
      bus.rsp_ready = 2'b10;
      applyStimulus(0, 1'b1, SUB, 64'd5, 64'd7);
      applyStimulus(1, 1'b1, ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      checkOutput("t4_rr_ready", 64'(bus.req_ready), 64'b01);
      cycle();
      applyStimulus(0, 1'b0, ADD, 64'd0, 64'd0);
      cycle();
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("t4_hold_valid_%0d", i), 64'(bus.rsp_valid), 64'b01);
         checkOutput($sformatf("t4_hold_result_%0d", i), bus.rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
         checkOutput($sformatf("t4_hold_flags_%0d", i), 64'(bus.rsp_flags), 64'b1000);
         checkOutput($sformatf("t4_hold_ready_%0d", i), 64'(bus.req_ready), 64'b00);
         cycle();
      end
      bus.rsp_ready = 2'b11;
      cycle();
      checkOutput("t4_release_ready", 64'(bus.req_ready), 64'b10);

      // Wrap-around: all-ones + 1 on req1
      cycle();
      applyStimulus(1, 1'b0, ADD, 64'd0, 64'd0);
      cycle();
      checkOutput("wrap_result", bus.rsp_result, 64'd0);
      checkOutput("wrap_flags", 64'(bus.rsp_flags), 64'b0110);
      cycle();

      // Test 5: complete req0 (pointer -> 1), then reset during req1 EXEC
      applyStimulus(0, 1'b1, ADD, 64'd10, 64'd20);
      cycle();
      applyStimulus(0, 1'b0, ADD, 64'd0, 64'd0);
      cycle();
      checkOutput("t5_pre_result", bus.rsp_result, 64'd30);
      cycle();
      applyStimulus(1, 1'b1, OR, 64'd1, 64'd2);
      checkOutput("t5_req1_ready", 64'(bus.req_ready), 64'b10);
      cycle();
      applyStimulus(1, 1'b0, ADD, 64'd0, 64'd0);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      #1;
      checkOutput("t5_rst_busy", 64'(bus.busy), 64'd0);
      checkOutput("t5_rst_rsp_valid", 64'(bus.rsp_valid), 64'b00);
      checkOutput("t5_rst_result", bus.rsp_result, 64'd0);
      checkOutput("t5_rst_flags", 64'(bus.rsp_flags), 64'd0);
      cycle();
      checkOutput("t5_no_late_rsp", 64'(bus.rsp_valid), 64'b00);
      applyStimulus(0, 1'b1, ADD, 64'd1, 64'd1);
      applyStimulus(1, 1'b1, OR, 64'd1, 64'd2);
      checkOutput("t5_ptr_reset_ready", 64'(bus.req_ready), 64'b01);
      cycle();
      applyStimulus(0, 1'b0, ADD, 64'd0, 64'd0);
      applyStimulus(1, 1'b0, ADD, 64'd0, 64'd0);
      cycle();
      checkOutput("t5_add_rsp_valid", 64'(bus.rsp_valid), 64'b01);
      checkOutput("t5_add_result", bus.rsp_result, 64'd2);
      checkOutput("t5_add_flags", 64'(bus.rsp_flags), 64'b0000);
      cycle();

`ifdef ALU_ARB_STATS_EN
      // Test 6: grant counters
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      runTxn(0);
      runTxn(1);
      runTxn(0);
      runTxn(1);
      runTxn(0);
      checkOutput("t6_stat_req0", 64'(stat_grants[31:0]), 64'd3);
      checkOutput("t6_stat_req1", 64'(stat_grants[63:32]), 64'd2);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      checkOutput("t6_stat_clear0", 64'(stat_grants[31:0]), 64'd0);
      checkOutput("t6_stat_clear1", 64'(stat_grants[63:32]), 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
